hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Stall/flush controller for the 5-stage pipeline. It covers the hazards that register bypass cannot resolve, by holding stages and inserting bubbles.
- Detects:
  - load-use hazards into EX;
  - operand hazards for branches resolved in ID;
  - instruction-memory and data-memory wait states;
  - taken-branch redirects.
- Drives the PC, IF/ID, ID/EX, EX/MEM and MEM/WB write, flush and bubble controls. Counts stall cycles for performance analysis.

Parameters:
CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous reset, active-high.
IF_ID_RegisterRs  in  5  rs of the instruction in ID.
IF_ID_RegisterRt  in  5  rt of the instruction in ID.
IF_ID_UsesRt  in  1  ID instruction reads rt as a source.
IF_ID_IsBranch  in  1  ID instruction is a conditional branch or register jump, resolved in ID.
BranchTaken  in  1  ID redirect taken this cycle.
ID_EX_MemRead  in  1  EX instruction is a load.
ID_EX_RegWrite  in  1  EX instruction writes a register.
ID_EX_RegisterRd  in  5  EX destination register.
imem_stall  in  1  fetch memory busy.
dmem_stall  in  1  data memory busy.
PC_Write  out  1  PC update enable.
IF_ID_Write  out  1  IF/ID update enable.
IF_ID_Flush  out  1  load a NOP into IF/ID.
ID_EX_Bubble  out  1  load a NOP into ID/EX.
EX_MEM_Write  out  1  EX/MEM update enable.
MEM_WB_Bubble  out  1  load a NOP into MEM/WB.
stall_count  out  CNT_W  cycles in which PC_Write was 0; saturates at all-ones.

Behaviour:
- Match: ID_EX_RegisterRd != 0 and (equal to IF_ID_RegisterRs, or equal to IF_ID_RegisterRt with IF_ID_UsesRt=1).
- States: RUN, LU_STALL, BR_STALL2, DMEM_WAIT. rst → RUN, stall_count=0.
- Outputs are a combinational function of state and inputs.
- While rst=1: PC_Write=0, IF_ID_Write=0, IF_ID_Flush=1, ID_EX_Bubble=1, EX_MEM_Write=1, MEM_WB_Bubble=1.
- Normal (no hazard): PC_Write=1, IF_ID_Write=1, EX_MEM_Write=1, all flush/bubble outputs 0.
- Priority within a cycle, highest first: dmem_stall, load/branch hazard, imem_stall, BranchTaken.
- dmem_stall=1 (any state):
  - PC_Write=0, IF_ID_Write=0, EX_MEM_Write=0, MEM_WB_Bubble=1; ID/EX holds (ID_EX_Bubble=0).
  - next state DMEM_WAIT; the state held before entry is retained as the resume state.
  - On dmem_stall falling, return to the resume state; the hazard check is re-evaluated that cycle.
- RUN:
  - load-use: ID_EX_MemRead=1 and match.
    - PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1.
    - → BR_STALL2 if IF_ID_IsBranch=1, else → LU_STALL.
  - branch-ALU: IF_ID_IsBranch=1, ID_EX_RegWrite=1, ID_EX_MemRead=0, and match.
    - same stall outputs; → LU_STALL.
  - imem_stall=1 with no hazard:
    - PC_Write=0, IF_ID_Flush=1; downstream flows.
    - BranchTaken is ignored that cycle; the ID instruction re-asserts it next cycle.
  - BranchTaken=1 with no hazard: IF_ID_Flush=1, PC_Write=1.
- LU_STALL:
  - exactly one bubble has already been inserted; outputs normal (the hazard is now covered by forwarding).
  - → RUN. The hazard check is NOT applied in this cycle, which guarantees at most one bubble per producer.
- BR_STALL2:
  - second stall for a load feeding a branch: PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1.
  - → LU_STALL.
- stall_count increments on every cycle with PC_Write=0 and rst=0. It holds at 2^CNT_W−1.
- Register 0 never matches. Simultaneous BranchTaken and hazard: the hazard wins and the flush is suppressed.

Decomposition:
- Shared pipeline package holds:
  - state encoding (2-bit enum: RUN=0, LU_STALL=1, BR_STALL2=2, DMEM_WAIT=3);
  - the NOP encoding;
  - REG_W=5.
- Sub-module hazard_match implements the register-compare logic (combinational, reusable by other units).
- FSM and counter stay in hazard_ctrl.

Test Plan:
- Load-use: ID_EX_MemRead=1, ID_EX_RegisterRd=3, IF_ID_RegisterRs=3 → one cycle with PC_Write=0, ID_EX_Bubble=1, then normal; stall_count=1.
- Load feeding branch: same plus IF_ID_IsBranch=1 → two consecutive stall cycles (RUN→BR_STALL2→LU_STALL); stall_count=2.
- Rd=0 or UsesRt=0 with an rt-only match → no stall; outputs normal.
- dmem_stall high 4 cycles during BR_STALL2 → EX_MEM_Write=0 and MEM_WB_Bubble=1 for 4 cycles. Then exactly one further stall cycle, then normal; stall_count=6.
- BranchTaken=1 with imem_stall=0 and no hazard → IF_ID_Flush=1, PC_Write=1. With a concurrent load-use → IF_ID_Flush=0, stall outputs asserted.
- rst asserted in BR_STALL2 → next cycle state RUN, stall_count=0; flush/bubble outputs asserted while rst=1.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_pkg
// Shared pipeline definitions for the hazard controller and its helpers:
//   - register-index width and the pipeline NOP encoding
//   - FSM state encoding for the stall/flush controller
//   - bundled pipeline control word and its canonical values
// -----------------------------------------------------------------------------
package hazard_ctrl_pkg;

    localparam int REG_W = 5;

    // All-zero word decodes as sll $0,$0,0: no architectural effect.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LU_STALL  = 2'd1,
        BR_STALL2 = 2'd2,
        DMEM_WAIT = 2'd3
    } hz_state_e;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_bubble;
        logic ex_mem_write;
        logic mem_wb_bubble;
    } hz_ctrl_t;

    // Everything advances, nothing squashed.
    localparam hz_ctrl_t CTRL_NORMAL = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    // Hold PC and IF/ID, inject a bubble into EX.
    localparam hz_ctrl_t CTRL_STALL  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    // Taken redirect: fetch the target, squash the wrong-path fetch.
    localparam hz_ctrl_t CTRL_FLUSH  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    // Fetch not ready: hold PC, feed a NOP into ID, downstream keeps flowing.
    localparam hz_ctrl_t CTRL_IMEM   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    // Data memory busy: freeze everything up to EX/MEM, bubble into WB.
    localparam hz_ctrl_t CTRL_DMEM   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    // Held in reset: nothing fetched, every latch loads a NOP.
    localparam hz_ctrl_t CTRL_RESET  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

endpackage : hazard_ctrl_pkg

// File: rtl/hazard_ctrl_match.sv
// -----------------------------------------------------------------------------
// hazard_match
// Combinational source/destination register compare, reusable by any unit
// that needs to know whether a producer's destination feeds a consumer.
// Ports:
//   rd_i      producer destination register
//   rs_i      consumer rs
//   rt_i      consumer rt
//   uses_rt_i consumer reads rt as a source
//   match_o   producer writes a register the consumer reads ($0 never matches)
// -----------------------------------------------------------------------------
module hazard_match
    import hazard_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] rd_i,
    input  logic [REG_W-1:0] rs_i,
    input  logic [REG_W-1:0] rt_i,
    input  logic             uses_rt_i,
    output logic             match_o
);

    logic rd_nonzero_s;
    logic rs_hit_s;
    logic rt_hit_s;

    assign rd_nonzero_s = (rd_i != {REG_W{1'b0}});
    assign rs_hit_s     = (rd_i == rs_i);
    assign rt_hit_s     = (rd_i == rt_i) && uses_rt_i;
    assign match_o      = rd_nonzero_s && (rs_hit_s || rt_hit_s);

endmodule : hazard_match

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Stall/flush controller for the 5-stage pipeline. Covers hazards that
// bypassing cannot resolve (load-use into EX, operands of branches resolved in
// ID), memory wait states and taken-branch redirects, and counts stall cycles.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   IF_ID_*                source registers / kind of the instruction in ID
//   BranchTaken            ID redirect taken this cycle
//   ID_EX_*                load / register-write / destination of EX instr
//   imem_stall, dmem_stall memory wait states
//   PC_Write .. MEM_WB_Bubble  pipeline enables and NOP injects (combinational)
//   stall_count            saturating count of cycles with PC_Write=0
// -----------------------------------------------------------------------------
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] IF_ID_RegisterRs,
    input  logic [REG_W-1:0] IF_ID_RegisterRt,
    input  logic             IF_ID_UsesRt,
    input  logic             IF_ID_IsBranch,
    input  logic             BranchTaken,
    input  logic             ID_EX_MemRead,
    input  logic             ID_EX_RegWrite,
    input  logic [REG_W-1:0] ID_EX_RegisterRd,
    input  logic             imem_stall,
    input  logic             dmem_stall,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Bubble,
    output logic             EX_MEM_Write,
    output logic             MEM_WB_Bubble,
    output logic [CNT_W-1:0] stall_count
);

    hz_state_e        state_q, state_d;
    hz_state_e        resume_q, resume_d;
    hz_state_e        eff_state_s;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    hz_ctrl_t         ctrl_s;
    logic             match_s;
    logic             load_use_s;
    logic             branch_alu_s;
    logic             hazard_s;

    hazard_match u_match (
        .rd_i      (ID_EX_RegisterRd),
        .rs_i      (IF_ID_RegisterRs),
        .rt_i      (IF_ID_RegisterRt),
        .uses_rt_i (IF_ID_UsesRt),
        .match_o   (match_s)
    );

    assign load_use_s   = ID_EX_MemRead && match_s;
    // An ALU result is forwarded to EX, not to ID, so a branch resolving in ID
    // must wait one cycle for it.
    assign branch_alu_s = IF_ID_IsBranch && ID_EX_RegWrite && !ID_EX_MemRead && match_s;
    assign hazard_s     = load_use_s || branch_alu_s;

    // Leaving a data-memory wait behaves exactly like the interrupted state,
    // so the hazard check is redone on the cycle dmem_stall drops.
    always_comb begin
        if (state_q == DMEM_WAIT) begin
            eff_state_s = resume_q;
        end else begin
            eff_state_s = state_q;
        end
    end

    // Next-state and pipeline-control decode in priority order.
    always_comb begin
        ctrl_s   = CTRL_NORMAL;
        state_d  = eff_state_s;
        resume_d = resume_q;
        if (rst) begin
            ctrl_s   = CTRL_RESET;
            state_d  = RUN;
            resume_d = RUN;
        end else if (dmem_stall) begin
            ctrl_s   = CTRL_DMEM;
            state_d  = DMEM_WAIT;
            resume_d = eff_state_s;
        end else begin
            case (eff_state_s)
                RUN: begin
                    if (hazard_s) begin
                        // A branch fed by a load needs the value in ID, one
                        // cycle later than an EX consumer would.
                        ctrl_s = CTRL_STALL;
                        if (load_use_s && IF_ID_IsBranch) begin
                            state_d = BR_STALL2;
                        end else begin
                            state_d = LU_STALL;
                        end
                    end else if (imem_stall) begin
                        // The redirect is dropped; the branch stays in ID and
                        // re-asserts BranchTaken next cycle.
                        ctrl_s  = CTRL_IMEM;
                        state_d = RUN;
                    end else if (BranchTaken) begin
                        ctrl_s  = CTRL_FLUSH;
                        state_d = RUN;
                    end else begin
                        ctrl_s  = CTRL_NORMAL;
                        state_d = RUN;
                    end
                end
                LU_STALL: begin
                    // Bubble already inserted; skipping the hazard check here
                    // keeps it to one bubble per producer.
                    state_d = RUN;
                    if (imem_stall) begin
                        ctrl_s = CTRL_IMEM;
                    end else if (BranchTaken) begin
                        ctrl_s = CTRL_FLUSH;
                    end else begin
                        ctrl_s = CTRL_NORMAL;
                    end
                end
                BR_STALL2: begin
                    ctrl_s  = CTRL_STALL;
                    state_d = LU_STALL;
                end
                default: begin
                    ctrl_s  = CTRL_NORMAL;
                    state_d = RUN;
                end
            endcase
        end
    end

    // Saturating stall-cycle counter next value.
    always_comb begin
        if (!ctrl_s.pc_write && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State, resume-state and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            resume_q <= RUN;
            cnt_q    <= {CNT_W{1'b0}};
        end else begin
            state_q  <= state_d;
            resume_q <= resume_d;
            cnt_q    <= cnt_d;
        end
    end

    assign PC_Write      = ctrl_s.pc_write;
    assign IF_ID_Write   = ctrl_s.if_id_write;
    assign IF_ID_Flush   = ctrl_s.if_id_flush;
    assign ID_EX_Bubble  = ctrl_s.id_ex_bubble;
    assign EX_MEM_Write  = ctrl_s.ex_mem_write;
    assign MEM_WB_Bubble = ctrl_s.mem_wb_bubble;
    assign stall_count   = cnt_q;

endmodule : hazard_ctrl
